viterbi_frame_ctrl: RTL and testbench

//  Frame sequencer for the encoder -> channel -> Viterbi decoder chain.
//  - Accepts a frame of payload bits from a valid/ready source and drives the encoder.
//  - Appends zero tail and flush bits so that every payload bit emerges from the decoder.
//  - Tags each output bit, checks it against the transmitted bit, and counts bit errors.
//  - Optionally schedules channel error injection.

---
 rtl/vfc_pkg.sv | 36 +++
 rtl/vfc_ref_fifo.sv | 78 +++++++
 rtl/viterbi_frame_ctrl.sv | 256 +++++++++++++++++++++++++
 tb/tb_viterbi_frame_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vfc_pkg.sv
// ============================================================================
// Module      : vfc_pkg
// Description : Shared types for the Viterbi frame controller: FSM state
//               encoding, reference FIFO entry layout and a saturating
//               increment helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vfc_pkg;

  // Frame sequencer states, explicit 2-bit encoding
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    FLUSH = 2'd2,
    WAIT  = 2'd3
  } vfc_state_e;

  // One reference entry per encoder symbol: tag=1 marks a payload bit,
  // tag=0 marks a tail/flush bit that produces no output.
  typedef struct packed {
    logic tag;
    logic bit_val;
  } ref_entry_t;

  localparam ref_entry_t c_flush_entry = '{tag: 1'b0, bit_val: 1'b0};

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vfc_ref_fifo.sv
// ============================================================================
// Module      : vfc_ref_fifo
// Description : Synchronous first-word-fall-through FIFO holding reference
//               entries for the symbols in flight through encoder, channel
//               and decoder. Provides occupancy and almost-full (two slots
//               left) for issue throttling.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vfc_ref_fifo
  import vfc_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  ref_entry_t push_data,
  input  logic       pop,
  output ref_entry_t pop_data,
  output logic [AW:0] count,
  output logic       afull,
  output logic       empty,
  output logic       full
);

  localparam int          c_depth     = 2 ** AW;
  localparam logic [AW:0] c_depth_lvl = (AW + 1)'(c_depth);
  localparam logic [AW:0] c_afull_lvl = (AW + 1)'(c_depth - 2);

  ref_entry_t      r_mem [c_depth];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;

  // Storage array: written on push, no reset needed since reads are gated by count
  always_ff @(posedge clk) begin
    if (push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leave count unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign pop_data = r_mem[r_rd_ptr];
  assign count    = r_count;
  assign empty    = (r_count == '0);
  assign full     = (r_count == c_depth_lvl);
  assign afull    = (r_count >= c_afull_lvl);

  // The sequencer throttles issue on afull and the decoder pipeline only pops
  // entries already pushed, so these can only fire on a design error.
  a_no_underflow : assert property (@(posedge clk) disable iff (rst) !(pop && empty));
  a_no_overflow  : assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

`default_nettype wire

// File: rtl/viterbi_frame_ctrl.sv
// ============================================================================
// Module      : viterbi_frame_ctrl
// Description : Frame sequencer for encoder -> channel -> Viterbi decoder.
//               Feeds payload bits to the encoder, appends tail and flush
//               zeros so every payload bit drains out of the decoder, pairs
//               decoder outputs with the transmitted bits and counts errors.
//               Optional channel error injection is built when the macro
//               VFC_ERR_INJ_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module viterbi_frame_ctrl
  import vfc_pkg::*;
#(
  parameter int LEN_W       = 8,
  parameter int TAIL_LEN    = 2,
  parameter int DEC_LAT     = 16,
  parameter int DEC_OUT_DLY = 1,
  parameter int FIFO_AW     = 5,
  parameter int CNT_W       = 16,
  parameter int ERR_N       = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [LEN_W-1:0] frame_len_i,
  input  logic             s_valid_i,
  input  logic             s_bit_i,
  output logic             s_ready_o,
  output logic             enc_enable_o,
  output logic             enc_bit_o,
  input  logic             enc_valid_i,
  output logic [1:0]       err_mask_o,
  output logic             dec_enable_o,
  input  logic             dec_bit_i,
  input  logic             inj_en_i,
  output logic             out_valid_o,
  output logic             out_bit_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] bit_err_cnt_o
);

  localparam int c_flush_n = TAIL_LEN + DEC_LAT;
  localparam int c_flush_w = $clog2(c_flush_n);
  localparam int c_sym_w   = $clog2(DEC_LAT + 1);

  localparam logic [c_flush_w-1:0] c_flush_last = c_flush_w'(c_flush_n - 1);
  localparam logic [c_sym_w-1:0]   c_sym_sat    = c_sym_w'(DEC_LAT);

  vfc_state_e           r_state;
  logic [LEN_W-1:0]     r_len;
  logic [LEN_W-1:0]     r_in_cnt;
  logic [LEN_W-1:0]     r_out_cnt;
  logic [c_flush_w-1:0] r_flush_cnt;
  logic [c_sym_w-1:0]   r_sym_cnt;

  logic                 r_pair_vld [DEC_OUT_DLY];
  ref_entry_t           r_pair_ent [DEC_OUT_DLY];

  logic                 w_start;
  logic                 w_accept;
  logic                 w_flush_issue;
  logic                 w_push;
  ref_entry_t           w_push_data;
  logic                 w_pop;
  ref_entry_t           w_pop_data;
  logic [FIFO_AW:0]     w_count;
  logic                 w_afull;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_pair_vld;
  ref_entry_t           w_pair_ent;
  logic                 w_out_fire;

  // ------------------------------------------------------------------
  // Issue side: accepted payload bits and flush zeros both enter the
  // reference FIFO in the same order they reach the encoder.
  // ------------------------------------------------------------------
  assign w_start       = (r_state == IDLE) && start_i && (frame_len_i != '0);
  assign s_ready_o     = (r_state == DATA) && !w_afull;
  assign w_accept      = s_ready_o && s_valid_i;
  assign w_flush_issue = (r_state == FLUSH) && !w_afull;
  assign w_push        = w_accept || w_flush_issue;
  assign w_push_data   = w_accept ? '{tag: 1'b1, bit_val: s_bit_i} : c_flush_entry;

  // Decoder output only becomes meaningful after DEC_LAT symbols; from then
  // on every decoder symbol retires exactly one reference entry.
  assign w_pop = dec_enable_o && (r_sym_cnt == c_sym_sat);

  vfc_ref_fifo #(
    .AW (FIFO_AW)
  ) u_ref_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (w_pop),
    .pop_data  (w_pop_data),
    .count     (w_count),
    .afull     (w_afull),
    .empty     (w_empty),
    .full      (w_full)
  );

  // Frame sequencer: IDLE -> DATA -> FLUSH -> WAIT, with registered encoder drive
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      enc_enable_o <= 1'b0;
      enc_bit_o    <= 1'b0;
      r_len        <= '0;
      r_in_cnt     <= '0;
      r_flush_cnt  <= '0;
    end else begin
      enc_enable_o <= 1'b0;
      enc_bit_o    <= 1'b0;
      done_o       <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_len       <= frame_len_i;
            r_in_cnt    <= '0;
            r_flush_cnt <= '0;
            r_state     <= DATA;
            busy_o      <= 1'b1;
          end
        end
        DATA: begin
          if (w_accept) begin
            enc_enable_o <= 1'b1;
            enc_bit_o    <= s_bit_i;
            if (r_in_cnt == r_len - LEN_W'(1)) begin
              r_in_cnt <= '0;
              r_state  <= FLUSH;
            end else begin
              r_in_cnt <= r_in_cnt + LEN_W'(1);
            end
          end
        end
        FLUSH: begin
          if (w_flush_issue) begin
            enc_enable_o <= 1'b1;
            enc_bit_o    <= 1'b0;
            if (r_flush_cnt == c_flush_last) begin
              r_flush_cnt <= '0;
              r_state     <= WAIT;
            end else begin
              r_flush_cnt <= r_flush_cnt + c_flush_w'(1);
            end
          end
        end
        WAIT: begin
          if (r_out_cnt == r_len) begin
            done_o  <= 1'b1;
            busy_o  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

  // Channel register stage and decoder warm-up counter (kept across frames,
  // because residual flush entries stay aligned with the decoder pipeline)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_enable_o <= 1'b0;
      r_sym_cnt    <= '0;
    end else begin
      dec_enable_o <= enc_valid_i;
      if (dec_enable_o && (r_sym_cnt != c_sym_sat)) begin
        r_sym_cnt <= r_sym_cnt + c_sym_w'(1);
      end
    end
  end

  // Delay popped entries until the decoder presents the matching output bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEC_OUT_DLY; i++) begin
        r_pair_vld[i] <= 1'b0;
        r_pair_ent[i] <= c_flush_entry;
      end
    end else begin
      r_pair_vld[0] <= w_pop;
      r_pair_ent[0] <= w_pop_data;
      for (int i = 1; i < DEC_OUT_DLY; i++) begin
        r_pair_vld[i] <= r_pair_vld[i-1];
        r_pair_ent[i] <= r_pair_ent[i-1];
      end
    end
  end

  assign w_pair_vld = r_pair_vld[DEC_OUT_DLY-1];
  assign w_pair_ent = r_pair_ent[DEC_OUT_DLY-1];
  assign w_out_fire = w_pair_vld && w_pair_ent.tag;

  // Payload output, per-frame output count and saturating bit-error count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_o   <= 1'b0;
      out_bit_o     <= 1'b0;
      r_out_cnt     <= '0;
      bit_err_cnt_o <= '0;
    end else begin
      out_valid_o <= w_out_fire;
      out_bit_o   <= w_out_fire ? dec_bit_i : 1'b0;
      if (w_start) begin
        r_out_cnt     <= '0;
        bit_err_cnt_o <= '0;
      end else if (w_out_fire) begin
        r_out_cnt <= r_out_cnt + LEN_W'(1);
        if ((dec_bit_i != w_pair_ent.bit_val) && (bit_err_cnt_o != '1)) begin
          bit_err_cnt_o <= bit_err_cnt_o + CNT_W'(1);
        end
      end
    end
  end

`ifdef VFC_ERR_INJ_EN
  logic [ERR_N-1:0] r_inj_cnt;

  // Injection symbol counter: restarts each frame, one step per encoder symbol
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inj_cnt <= '0;
    end else if (w_start) begin
      r_inj_cnt <= '0;
    end else if (enc_valid_i) begin
      r_inj_cnt <= r_inj_cnt + ERR_N'(1);
    end
  end

  // Flip one coded bit on the last symbol of every 2**ERR_N-symbol block
  assign err_mask_o = (enc_valid_i && inj_en_i && (r_inj_cnt == '1)) ? 2'b01 : 2'b00;

  logic w_unused;
  assign w_unused = ^{w_count, w_full, w_empty};
`else
  assign err_mask_o = 2'b00;

  logic w_unused;
  assign w_unused = ^{w_count, w_full, w_empty, inj_en_i};
`endif

endmodule

`default_nettype wire

// File: tb/tb_viterbi_frame_ctrl.sv
// ============================================================================
// Module      : tb_viterbi_frame_ctrl
// Description : Self-checking bench for viterbi_frame_ctrl. Models a
//               one-cycle encoder and an ideal traceback decoder (output =
//               symbol DEC_LAT earlier, one cycle after its enable), with an
//               optional single-symbol inversion; a scoreboard queue holds
//               the expected payload outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_viterbi_frame_ctrl;

  localparam int LEN_W   = 8;
  localparam int CNT_W   = 16;
  localparam int DEC_LAT = 16;
  localparam int FLUSH_N = 18;

  logic             clk = 1'b0;
  logic             rst;
  logic             start_i;
  logic [LEN_W-1:0] frame_len_i;
  logic             s_valid_i;
  logic             s_bit_i;
  logic             s_ready_o;
  logic             enc_enable_o;
  logic             enc_bit_o;
  logic             enc_valid_i;
  logic [1:0]       err_mask_o;
  logic             dec_enable_o;
  logic             dec_bit_i;
  logic             inj_en_i;
  logic             out_valid_o;
  logic             out_bit_o;
  logic             busy_o;
  logic             done_o;
  logic [CNT_W-1:0] bit_err_cnt_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  viterbi_frame_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .frame_len_i   (frame_len_i),
    .s_valid_i     (s_valid_i),
    .s_bit_i       (s_bit_i),
    .s_ready_o     (s_ready_o),
    .enc_enable_o  (enc_enable_o),
    .enc_bit_o     (enc_bit_o),
    .enc_valid_i   (enc_valid_i),
    .err_mask_o    (err_mask_o),
    .dec_enable_o  (dec_enable_o),
    .dec_bit_i     (dec_bit_i),
    .inj_en_i      (inj_en_i),
    .out_valid_o   (out_valid_o),
    .out_bit_o     (out_bit_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .bit_err_cnt_o (bit_err_cnt_o)
  );

  task automatic check_eq(input string tag, input longint actual, input longint expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // ---------------- encoder / channel / decoder model ----------------
  logic enc_v, enc_bq, ch_b, dec_b;
  int   enc_sym_total = 0;   // model-owned
  int   start_sym     = 0;   // stimulus-owned
  int   flip_idx      = -1;  // stimulus-owned
  bit   hist[$];

  assign enc_valid_i = enc_v;
  assign dec_bit_i   = dec_b;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      enc_v  <= 1'b0;
      enc_bq <= 1'b0;
      ch_b   <= 1'b0;
      dec_b  <= 1'b0;
      hist.delete();
    end else begin
      enc_v  <= enc_enable_o;
      enc_bq <= enc_bit_o ^ (enc_enable_o && (flip_idx >= 0) &&
                             (enc_sym_total - start_sym == flip_idx));
      if (enc_enable_o) enc_sym_total <= enc_sym_total + 1;
      ch_b <= enc_bq;
      if (dec_enable_o) begin
        hist.push_back(ch_b);
        if (hist.size() > DEC_LAT) dec_b <= hist[hist.size() - 1 - DEC_LAT];
        else                       dec_b <= 1'b0;
      end
    end
  end

  // ---------------- output monitor / scoreboard ----------------
  bit exp_q[$];
  int out_pulses = 0, enc_cycles = 0, done_pulses = 0;
  int inj_total = 0;   // monitor-owned
  int inj_base  = 0;   // stimulus-owned

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid_o) begin
        out_pulses++;
        if (exp_q.size() == 0) check_eq("stale_out", 1, 0);
        else                   check_eq("out_bit", out_bit_o, exp_q.pop_front());
      end
      if (enc_enable_o) enc_cycles++;
      if (done_o)       done_pulses++;
      if (enc_valid_i) begin
`ifdef VFC_ERR_INJ_EN
        check_eq("err_mask", err_mask_o,
                 (inj_en_i && ((inj_total - inj_base) % 8 == 7)) ? 2'b01 : 2'b00);
`else
        check_eq("err_mask", err_mask_o, 2'b00);
`endif
        inj_total++;
      end
    end
  end

  // ---------------- stimulus tasks ----------------
  int snap_out, snap_enc, snap_done;

  task automatic start_frame(input int len, input int flip);
    @(negedge clk);
    flip_idx    = flip;
    start_sym   = enc_sym_total;
    inj_base    = inj_total;
    snap_out    = out_pulses;
    snap_enc    = enc_cycles;
    snap_done   = done_pulses;
    frame_len_i = LEN_W'(len);
    start_i     = 1'b1;
    @(negedge clk);
    start_i     = 1'b0;
    check_eq("busy_after_start", busy_o, 1);
  endtask

  // Feed n payload bits (MSB of pattern first); toggle inserts bubbles and
  // holds a competing start request that must be ignored.
  task automatic feed(input logic [31:0] pat, input int len, input int n,
                      input bit toggle, input int flip);
    int i = 0;
    int cyc = 0;
    start_i     = toggle;
    frame_len_i = 8'd3;
    while (i < n && cyc < 500) begin
      s_valid_i = toggle ? (cyc % 2 == 0) : 1'b1;
      s_bit_i   = s_valid_i ? pat[len-1-i] : 1'($urandom_range(1));
      #1;
      if (s_valid_i && s_ready_o) begin
        exp_q.push_back(pat[len-1-i] ^ (i == flip));
        i++;
      end
      @(negedge clk);
      cyc++;
    end
    s_valid_i = 1'b0;
    start_i   = 1'b0;
    check_eq("feed_timeout", i, n);
  endtask

  task automatic finish_frame(input int len, input int exp_errs);
    int cyc = 0;
    while (done_pulses == snap_done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("done_timeout", (cyc < 2000), 1);
    repeat (5) @(negedge clk);
    check_eq("done_pulses", done_pulses - snap_done, 1);
    check_eq("out_pulses", out_pulses - snap_out, len);
    check_eq("enc_cycles", enc_cycles - snap_enc, len + FLUSH_N);
    check_eq("bit_err_cnt", bit_err_cnt_o, exp_errs);
    check_eq("sb_empty", exp_q.size(), 0);
    check_eq("busy_after_done", busy_o, 0);
  endtask

  task automatic run_frame(input logic [31:0] pat, input int len, input bit toggle,
                           input int flip, input int exp_errs);
    start_frame(len, flip);
    feed(pat, len, len, toggle, flip);
    finish_frame(len, exp_errs);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; start_i = 1'b0; frame_len_i = '0; s_valid_i = 1'b0;
    s_bit_i = 1'b0; inj_en_i = 1'b0;

    // 1: reset with random inputs
    repeat (6) begin
      @(negedge clk);
      start_i     = 1'($urandom_range(1));
      frame_len_i = LEN_W'($urandom_range(255));
      s_valid_i   = 1'($urandom_range(1));
      s_bit_i     = 1'($urandom_range(1));
      inj_en_i    = 1'($urandom_range(1));
      #1;
      check_eq("reset_outputs",
               {s_ready_o, enc_enable_o, enc_bit_o, err_mask_o, dec_enable_o,
                out_valid_o, out_bit_o, busy_o, done_o, bit_err_cnt_o}, 0);
    end
    start_i = 1'b0; s_valid_i = 1'b0; inj_en_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("idle_busy", busy_o, 0);

    // 2: nominal frame
    run_frame(32'b10110010, 8, 1'b0, -1, 0);

    // 3: zero-length start is ignored
    snap_enc = enc_cycles;
    @(negedge clk);
    frame_len_i = '0; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("len0_busy", busy_o, 0);
    check_eq("len0_enc", enc_cycles - snap_enc, 0);

    // 4: bubbles on the source, stray start during DATA
    run_frame(32'b10110010, 8, 1'b1, -1, 0);

    // 5: injection on, decoder input for payload bit 3 inverted
    inj_en_i = 1'b1;
    run_frame(32'b10110010, 8, 1'b0, 3, 1);
    inj_en_i = 1'b0;

    // 6: reset in the middle of DATA, then a short frame
    start_frame(8, -1);
    feed(32'b11111111, 8, 3, 1'b0, -1);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("abort_busy", busy_o, 0);
    check_eq("abort_err_cnt", bit_err_cnt_o, 0);
    run_frame(32'b1100, 4, 1'b0, -1, 0);

    repeat (30) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
